credit_sender: RTL and testbench

Upstream partner of the credit receiver on a credit-flow-controlled link. Accepts words from a local ready/valid producer, spends one credit per word, and forwards each word to the link as a single-cycle valid pulse with a one-cycle registered latency. Replenishes credits from the receiver's credit-return pulses. Runs a reset handshake with the receiver so neither side trades credits while the other is in reset.

---
 rtl/credit_sender.sv | 72 +++++++
 tb/tb_credit_sender.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/credit_sender.sv
// Credit-flow-controlled link sender: spends one credit per forwarded word and
// runs the reset handshake with the receiver before trading credits.
module credit_sender #(
    parameter int WIDTH       = 8,
    parameter int MAX_CREDITS = 4,
    localparam int CW         = $clog2(MAX_CREDITS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    output logic             push_ready,
    input  logic             push_valid,
    input  logic [WIDTH-1:0] push_data,
    output logic             push_sender_in_reset,
    input  logic             push_receiver_in_reset,
    output logic             push_credit_stall,
    input  logic             push_credit,
    output logic             pop_valid,
    output logic [WIDTH-1:0] pop_data,
    output logic [CW-1:0]    credit_count,
    output logic             credit_available,
    output logic             credit_overflow
);

    typedef enum logic [1:0] {RESET, SYNC, ACTIVE} state_t;

    state_t state;
    logic   active;
    logic   at_max;
    logic   transfer;

    assign active   = (state == ACTIVE);
    assign at_max   = (credit_count == CW'(MAX_CREDITS));
    assign transfer = push_valid & push_ready;

    assign push_ready           = active & (credit_count != '0);
    assign credit_available     = push_ready;
    assign push_sender_in_reset = ~active;
    assign push_credit_stall    = ~active | at_max;

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= RESET;
            credit_count    <= '0;
            pop_valid       <= 1'b0;
            pop_data        <= '0;
            credit_overflow <= 1'b0;
        end else begin
            // A word accepted in the cycle the receiver drops into reset still goes out.
            pop_valid <= transfer;
            if (transfer) pop_data <= push_data;

            case (state)
                RESET: state <= SYNC;
                SYNC: if (!push_receiver_in_reset) state <= ACTIVE;
                ACTIVE: begin
                    if (push_credit && at_max && !transfer) credit_overflow <= 1'b1;
                    // The receiver reloads its own credits on leaving reset, so ours are void.
                    if (push_receiver_in_reset) begin
                        state        <= SYNC;
                        credit_count <= '0;
                    end else if (push_credit && !transfer && !at_max) begin
                        credit_count <= credit_count + CW'(1);
                    end else if (transfer && !push_credit) begin
                        credit_count <= credit_count - CW'(1);
                    end
                end
                default: state <= RESET;
            endcase
        end
    end

endmodule

// File: tb/tb_credit_sender.sv
// Directed handshake/credit scenarios followed by random traffic, all checked
// every cycle against a behavioural model of the sender.
module tb_credit_sender;

    localparam int WIDTH = 8;
    localparam int MAXC  = 4;
    localparam int CW    = $clog2(MAXC + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             push_ready;
    logic             push_valid;
    logic [WIDTH-1:0] push_data;
    logic             push_sender_in_reset;
    logic             push_receiver_in_reset;
    logic             push_credit_stall;
    logic             push_credit;
    logic             pop_valid;
    logic [WIDTH-1:0] pop_data;
    logic [CW-1:0]    credit_count;
    logic             credit_available;
    logic             credit_overflow;

    int passed = 0;
    int total  = 0;

    credit_sender #(.WIDTH(WIDTH), .MAX_CREDITS(MAXC)) dut (
        .clk(clk), .rst(rst),
        .push_ready(push_ready), .push_valid(push_valid), .push_data(push_data),
        .push_sender_in_reset(push_sender_in_reset),
        .push_receiver_in_reset(push_receiver_in_reset),
        .push_credit_stall(push_credit_stall), .push_credit(push_credit),
        .pop_valid(pop_valid), .pop_data(pop_data),
        .credit_count(credit_count), .credit_available(credit_available),
        .credit_overflow(credit_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Model: phase 0 = sender in reset, 1 = waiting on receiver, 2 = trading.
    int         m_phase = 0;
    int         m_cnt   = 0;
    bit         m_pv    = 0;
    int         m_pd    = 0;
    bit         m_ovf   = 0;
    int         m_pops  = 0;

    always @(posedge clk) begin
        bit trading, xfer;
        if (rst) begin
            m_phase = 0; m_cnt = 0; m_pv = 0; m_pd = 0; m_ovf = 0;
        end else begin
            trading = (m_phase == 2);
            xfer    = trading && m_cnt > 0 && push_valid;
            m_pv    = xfer;
            if (xfer) m_pd = push_data;
            if (trading) begin
                if (push_credit && m_cnt == MAXC && !xfer) m_ovf = 1;
                m_cnt = m_cnt + int'(push_credit) - int'(xfer);
                if (m_cnt > MAXC) m_cnt = MAXC;
            end
            case (m_phase)
                0: m_phase = 1;
                1: if (!push_receiver_in_reset) m_phase = 2;
                default: if (push_receiver_in_reset) begin m_phase = 1; m_cnt = 0; end
            endcase
        end
        #1;
        if (pop_valid) m_pops++;
        check("push_ready",  int'(push_ready), int'(m_phase == 2 && m_cnt > 0));
        check("credit_available", int'(credit_available), int'(m_phase == 2 && m_cnt > 0));
        check("sender_in_reset", int'(push_sender_in_reset), int'(m_phase != 2));
        check("credit_stall", int'(push_credit_stall), int'(m_phase != 2 || m_cnt == MAXC));
        check("credit_count", int'(credit_count), m_cnt);
        check("pop_valid", int'(pop_valid), int'(m_pv));
        check("pop_data", int'(pop_data), m_pd);
        check("credit_overflow", int'(credit_overflow), int'(m_ovf));
    end

    // Advance one cycle; returns after the model compare has run.
    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        int pops_before;
        rst = 1; push_valid = 0; push_data = '0; push_receiver_in_reset = 0; push_credit = 0;

        // Reset and handshake
        cyc(3);
        check("lit_reset_sir", int'(push_sender_in_reset), 1);
        check("lit_reset_stall", int'(push_credit_stall), 1);
        check("lit_reset_count", int'(credit_count), 0);
        rst = 0;
        cyc();
        check("lit_sync_sir", int'(push_sender_in_reset), 1);
        cyc();
        check("lit_active_sir", int'(push_sender_in_reset), 0);
        check("lit_active_ready", int'(push_ready), 0);

        // Credit load
        push_credit = 1;
        for (int i = 1; i <= 4; i++) begin
            cyc();
            check("lit_load_count", int'(credit_count), i);
        end
        check("lit_load_stall", int'(push_credit_stall), 1);
        push_credit = 0;

        // Burst of 6 with 4 credits
        for (int i = 0; i < 6; i++) begin
            push_valid = 1; push_data = WIDTH'(8'h10 + i);
            cyc();
            check("lit_burst_valid", int'(pop_valid), int'(i < 4));
            if (i < 4) check("lit_burst_data", int'(pop_data), 'h10 + i);
        end
        push_valid = 0;
        check("lit_burst_count", int'(credit_count), 0);
        check("lit_burst_ready", int'(push_ready), 0);

        // Simultaneous inc/dec at 2 and at MAX
        push_credit = 1; cyc(2); push_credit = 0;
        push_credit = 1; push_valid = 1; push_data = 8'hAA;
        cyc();
        check("lit_simul2_count", int'(credit_count), 2);
        check("lit_simul2_pop", int'(pop_valid), 1);
        push_valid = 0; cyc(2);
        check("lit_full_count", int'(credit_count), 4);
        push_valid = 1; push_data = 8'hBB;
        cyc();
        check("lit_simul4_count", int'(credit_count), 4);
        check("lit_simul4_ovf", int'(credit_overflow), 0);

        // Overflow
        push_valid = 0;
        cyc();
        check("lit_ovf_flag", int'(credit_overflow), 1);
        check("lit_ovf_count", int'(credit_count), 4);
        push_credit = 0;
        cyc(3);
        check("lit_ovf_sticky", int'(credit_overflow), 1);

        // Receiver reset mid-stream from count 3
        push_valid = 1; push_data = 8'h33; cyc(); push_valid = 0;
        check("lit_rx_pre_count", int'(credit_count), 3);
        push_receiver_in_reset = 1;
        cyc();
        push_credit = 1;
        cyc(4);
        check("lit_rx_count", int'(credit_count), 0);
        check("lit_rx_sir", int'(push_sender_in_reset), 1);
        push_receiver_in_reset = 0; push_credit = 0;
        cyc();
        check("lit_rx_back", int'(push_sender_in_reset), 0);

        // Sender reset with a pending transfer
        push_credit = 1; cyc(2); push_credit = 0;
        push_valid = 1; push_data = 8'h77; rst = 1;
        cyc();
        check("lit_rst_pop", int'(pop_valid), 0);
        check("lit_rst_count", int'(credit_count), 0);
        check("lit_rst_ovf", int'(credit_overflow), 0);
        rst = 0; push_valid = 0;
        cyc(2);

        // Random traffic
        pops_before = m_pops;
        for (int i = 0; i < 3000; i++) begin
            rst                    = ($urandom_range(0, 199) == 0);
            push_valid             = ($urandom_range(0, 3) != 0);
            push_data              = WIDTH'($urandom);
            push_receiver_in_reset = push_receiver_in_reset ? ($urandom_range(0, 3) != 0)
                                                            : ($urandom_range(0, 99) == 0);
            push_credit            = push_credit_stall ? ($urandom_range(0, 19) == 0)
                                                       : ($urandom_range(0, 1) == 1);
            cyc();
        end
        check("rand_traffic_seen", int'(m_pops > pops_before + 100), 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
